// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbiter granting one requester at a time a timed interval on a shared counter
// Ports: clk, reset_n (async active-low); tick_en count qualifier; req[NUM_REQ] level requests;
//        final_value[NUM_REQ*CNT_WIDTH] per-requester terminal counts; gnt/done one-hot grant and
//        completion pulse; busy high outside IDLE; count shared counter value.
module timer_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           tick_en,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]   final_value,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           count
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state_q;
    logic [NUM_REQ-1:0]   gnt_q, done_q;
    logic                 busy_q;
    logic [CNT_WIDTH-1:0] count_q, term_q;
    logic [IW-1:0]        last_q, idx_q, win_d;
    // Descending scan so the requester nearest after last_q overwrites farther ones.
    always_comb begin
        win_d = last_q;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(last_q) + k) % NUM_REQ]) win_d = IW'((int'(last_q) + k) % NUM_REQ);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            term_q  <= '0;
            idx_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: if (|req) begin
                    state_q <= RUN;
                    gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
                    term_q  <= final_value[win_d*CNT_WIDTH +: CNT_WIDTH];
                    count_q <= '0;
                    idx_q   <= win_d;
                    busy_q  <= 1'b1;
                end
                // A dropped request aborts ahead of any tick completing in the same cycle.
                RUN: if (!req[idx_q]) begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= idx_q;
                end else if (tick_en) begin
                    if (count_q == term_q) begin
                        state_q <= DONE;
                        done_q  <= gnt_q;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= idx_q;
                end
            endcase
        end
    end
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: scoreboard bench for timer_arbiter with NUM_REQ=4, CNT_WIDTH=8
module tb_timer_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick_en = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] final_value = '0;
    logic [3:0]  gnt, done;
    logic        busy;
    logic [7:0]  count;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;
    exp_t q[$];
    int         m_state, m_idx, m_last;
    logic [3:0] m_gnt, m_done;
    logic       m_busy;
    logic [7:0] m_cnt, m_term;
    logic [3:0] exp_g [5];
    timer_arbiter #(.NUM_REQ(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .req(req),
        .final_value(final_value), .gnt(gnt), .done(done), .busy(busy), .count(count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic m_reset();
        m_state = 0; m_gnt = '0; m_done = '0; m_busy = 1'b0;
        m_cnt = '0; m_term = '0; m_idx = 0; m_last = 3;
    endtask
    task automatic model_step(input logic [3:0] r, input logic t, input logic [31:0] f);
        int w;
        case (m_state)
            0: begin
                m_done = '0;
                if (r != 0) begin
                    w = -1;
                    for (int k = 1; k <= 4; k++)
                        if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
                    m_idx = w; m_gnt = 4'(1 << w); m_term = f[w*8 +: 8];
                    m_cnt = '0; m_busy = 1'b1; m_state = 1;
                end
            end
            1: begin
                if (!r[m_idx]) begin
                    m_state = 0; m_gnt = '0; m_busy = 1'b0; m_last = m_idx;
                end else if (t) begin
                    if (m_cnt == m_term) begin m_state = 2; m_done = m_gnt; end
                    else m_cnt = m_cnt + 8'd1;
                end
            end
            default: begin
                m_state = 0; m_gnt = '0; m_done = '0; m_busy = 1'b0; m_last = m_idx;
            end
        endcase
    endtask
    task automatic cycle(input logic [3:0] r, input logic t, input logic [31:0] f);
        exp_t e;
        req = r; tick_en = t; final_value = f;
        model_step(r, t, f);
        e.gnt = m_gnt; e.done = m_done; e.busy = m_busy; e.cnt = m_cnt;
        q.push_back(e);
        @(posedge clk); #1;
        e = q.pop_front();
        check("gnt", gnt, e.gnt);
        check("done", done, e.done);
        check("busy", busy, e.busy);
        check("count", count, e.cnt);
    endtask
    task automatic wait_done(input string tag, input logic [3:0] r, input logic [31:0] f, input int exp_cyc);
        int n = 0;
        do begin cycle(r, 1'b1, f); n++; end while (done == 0 && n < 300);
        check(tag, n, exp_cyc);
    endtask
    task automatic pulse_reset();
        reset_n = 1'b0; #1;
        m_reset();
        @(negedge clk); reset_n = 1'b1;
    endtask
    initial begin
        m_reset();
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        #3;
        check("rst_gnt", gnt, 0); check("rst_done", done, 0);
        check("rst_busy", busy, 0); check("rst_count", count, 0);
        @(negedge clk); reset_n = 1'b1;
        // single requester, terminal 3
        wait_done("t3_latency", 4'b0001, 32'h0000_0003, 5);
        check("t3_done", done, 4'b0001);
        check("t3_count", count, 3);
        cycle(4'b0000, 1'b1, 32'h0);
        // round robin across all four, terminals 1
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            wait_done("rr_period", 4'b1111, 32'h0101_0101, i == 0 ? 3 : 4);
            check("rr_gnt", gnt, exp_g[i]);
        end
        cycle(4'b0000, 1'b1, 32'h0);
        // tick_en gating, terminal 2
        cycle(4'b0001, 1'b1, 32'h0000_0002);
        check("gate_gnt", gnt, 4'b0001);
        cycle(4'b0001, 1'b1, 32'h2); cycle(4'b0001, 1'b0, 32'h2);
        cycle(4'b0001, 1'b1, 32'h2); cycle(4'b0001, 1'b0, 32'h2);
        check("gate_nodone", done, 0);
        cycle(4'b0001, 1'b1, 32'h2);
        check("gate_done", done, 4'b0001);
        cycle(4'b0000, 1'b1, 32'h0);
        // abort of requester 2 at count 1, pending 1010
        cycle(4'b0100, 1'b1, 32'h0005_0000);
        check("ab_gnt", gnt, 4'b0100);
        cycle(4'b0100, 1'b1, 32'h0005_0000);
        check("ab_count", count, 1);
        cycle(4'b1010, 1'b1, 32'h0005_0000);
        check("ab_idle_gnt", gnt, 0); check("ab_nodone", done, 0);
        cycle(4'b1010, 1'b1, 32'h0005_0000);
        check("ab_next", gnt, 4'b1000);
        cycle(4'b0000, 1'b1, 32'h0);
        // asynchronous reset at count 5
        cycle(4'b0001, 1'b1, 32'h0000_000A);
        for (int i = 0; i < 5; i++) cycle(4'b0001, 1'b1, 32'h0000_000A);
        check("ar_count5", count, 5);
        #2 reset_n = 1'b0; #1;
        check("ar_gnt", gnt, 0); check("ar_done", done, 0);
        check("ar_busy", busy, 0); check("ar_count", count, 0);
        m_reset();
        @(negedge clk); reset_n = 1'b1;
        cycle(4'b0110, 1'b1, 32'h0);
        check("ar_first", gnt, 4'b0010);
        cycle(4'b0000, 1'b1, 32'h0);
        // terminal 0 and 255 boundaries
        wait_done("b0_latency", 4'b0001, 32'h0000_0000, 2);
        check("b0_count", count, 0);
        cycle(4'b0000, 1'b1, 32'h0);
        wait_done("b255_latency", 4'b0001, 32'h0000_00FF, 257);
        check("b255_count", count, 255);
        cycle(4'b0000, 1'b1, 32'h0);
        // terminal latched at grant ignores later final_value changes
        cycle(4'b0001, 1'b1, 32'h0000_0002);
        wait_done("latch_latency", 4'b0001, 32'h0000_0000, 3);
        check("latch_count", count, 2);
        cycle(4'b0000, 1'b1, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
